// File: rtl/mux_pkg.sv
// Shared constants and state type for the 32:1 mux sequencing stage.
package mux_pkg;
   localparam int MUX_WIDTH = 32;
   localparam int MUX_SEL_W = 5;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ser_state_t;
endpackage

// File: rtl/mux32to1.sv
// 32:1 bit multiplexer: Y = I[S], purely combinational.
module mux32to1
   import mux_pkg::*;
(
   input  logic [MUX_SEL_W-1:0] S,
   input  logic [MUX_WIDTH-1:0] I,
   output logic                 Y
);
   assign Y = I[S];
endmodule

// File: rtl/mux_serializer_seq.sv
// Loads a parallel word and walks the mux select across a programmable bit range,
// emitting one bit per accepted beat over valid/ready/last.
module mux_serializer_seq
   import mux_pkg::*;
#(
   parameter int WIDTH = MUX_WIDTH,
   parameter int SEL_W = MUX_SEL_W
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0] in_count,
   input  logic             in_msb_first,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_bit,
   output logic             out_last,
   output logic [SEL_W-1:0] out_sel,
   output logic             done
);
   ser_state_t       r_state;
   logic [WIDTH-1:0] r_word;
   logic [SEL_W-1:0] r_sel;
   logic [SEL_W-1:0] r_remaining;
   logic             r_dir;
   logic             r_done;

   logic             w_load;
   logic             w_beat;
   logic             w_last;

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == SHIFT);
   assign w_load    = in_valid && in_ready;
   assign w_beat    = out_valid && out_ready;
   // remaining stays 0 after a word, so gate with SHIFT to keep out_last low in IDLE
   assign w_last    = out_valid && (r_remaining == '0);

   assign out_last  = w_last;
   assign out_sel   = r_sel;
   assign done      = r_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_word      <= '0;
         r_sel       <= '0;
         r_remaining <= '0;
         r_dir       <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_load) begin
                  r_word      <= in_data;
                  r_remaining <= in_count;
                  r_dir       <= in_msb_first;
                  r_sel       <= in_msb_first ? in_count : '0;
                  r_state     <= SHIFT;
               end
            end
            SHIFT: begin
               if (w_beat) begin
                  if (w_last) begin
                     r_state <= IDLE;
                     r_done  <= 1'b1;
                  end else begin
                     r_remaining <= r_remaining - 1'b1;
                     r_sel       <= r_dir ? (r_sel - 1'b1) : (r_sel + 1'b1);
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   mux32to1 u_mux (
      .S (r_sel),
      .I (r_word),
      .Y (out_bit)
   );
endmodule

// File: tb/tb_mux_serializer_seq.sv
// Self-checking bench: queue-based beat model checked every cycle plus directed literal checks.
module tb_mux_serializer_seq;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = '0;
   logic [4:0]  in_count = '0;
   logic        in_msb_first = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        out_bit;
   logic        out_last;
   logic [4:0]  out_sel;
   logic        done;

   int checks = 0;
   int errors = 0;
   int rdy_mode = 0;
   int rcyc = 0;

   typedef struct {
      logic       b;
      logic [4:0] s;
      logic       l;
   } beat_t;

   beat_t      exp_q[$];
   logic       exp_done = 1'b0;
   logic       bit_log[$];
   logic [4:0] sel_log[$];

   mux_serializer_seq dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_count     (in_count),
      .in_msb_first (in_msb_first),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_bit      (out_bit),
      .out_last     (out_last),
      .out_sel      (out_sel),
      .done         (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   // Reference model: a word expands into its full list of beats at load time.
   task automatic model_load(input logic [31:0] d, input logic [4:0] cnt, input logic msb);
      beat_t bt;
      int idx;
      for (int k = 0; k <= int'(cnt); k++) begin
         idx  = msb ? (int'(cnt) - k) : k;
         bt.b = d[idx];
         bt.s = 5'(idx);
         bt.l = (k == int'(cnt));
         exp_q.push_back(bt);
      end
      $display("load data=%08h count=%0d msb_first=%0d", d, cnt, msb);
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         exp_done = 1'b0;
         chk("rst_in_ready", in_ready, 1);
         chk("rst_out_valid", out_valid, 0);
         chk("rst_out_last", out_last, 0);
         chk("rst_done", done, 0);
         chk("rst_out_sel", out_sel, 0);
      end else begin
         chk("in_ready", in_ready, (exp_q.size() == 0));
         chk("out_valid", out_valid, (exp_q.size() != 0));
         chk("done", done, exp_done);
         if (exp_q.size() != 0) begin
            chk("out_bit", out_bit, exp_q[0].b);
            chk("out_sel", out_sel, exp_q[0].s);
            chk("out_last", out_last, exp_q[0].l);
         end
         exp_done = 1'b0;
         if (exp_q.size() == 0) begin
            if (in_valid) model_load(in_data, in_count, in_msb_first);
         end else if (out_ready) begin
            bit_log.push_back(exp_q[0].b);
            sel_log.push_back(exp_q[0].s);
            if (exp_q[0].l) exp_done = 1'b1;
            void'(exp_q.pop_front());
         end
      end
   end

   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = ((rcyc % 3) == 0);
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
      rcyc++;
   end

   task automatic wait_ready();
      int n;
      n = 0;
      while (!in_ready && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) chk("wait_in_ready_timeout", 0, 1);
   endtask

   task automatic load(input logic [31:0] d, input logic [4:0] cnt, input logic msb);
      wait_ready();
      in_valid = 1'b1; in_data = d; in_count = cnt; in_msb_first = msb;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data = $urandom; in_count = 5'($urandom); in_msb_first = 1'($urandom);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!done && n < 300);
      if (!done) chk("wait_done_timeout", 0, 1);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("idle_in_ready", in_ready, 1);
      chk("idle_out_valid", out_valid, 0);
      chk("idle_done", done, 0);
      chk("idle_out_sel", out_sel, 0);

      // Ascending full word, out_ready held high
      bit_log.delete(); sel_log.delete();
      rdy_mode = 0;
      load(32'hA5A5_0001, 5'd31, 1'b0);
      wait_done();
      chk("t1_in_ready_at_done", in_ready, 1);
      chk("t1_beats", bit_log.size(), 32);
      if (bit_log.size() == 32) begin
         chk("t1_bit0", bit_log[0], 1);
         chk("t1_bit1", bit_log[1], 0);
         chk("t1_bit3", bit_log[3], 0);
         chk("t1_sel31", sel_log[31], 31);
      end

      // Descending full word
      bit_log.delete(); sel_log.delete();
      load(32'h8000_0003, 5'd31, 1'b1);
      wait_done();
      chk("t2_beats", bit_log.size(), 32);
      if (bit_log.size() == 32) begin
         chk("t2_bit0", bit_log[0], 1);
         chk("t2_bit1", bit_log[1], 0);
         chk("t2_bit30", bit_log[30], 1);
         chk("t2_bit31", bit_log[31], 1);
         chk("t2_sel_first", sel_log[0], 31);
         chk("t2_sel_last", sel_log[31], 0);
      end

      // Short word with stalling downstream
      bit_log.delete(); sel_log.delete();
      rdy_mode = 1;
      load(32'h0000_0004, 5'd2, 1'b0);
      wait_done();
      chk("t3_beats", bit_log.size(), 3);
      if (bit_log.size() == 3) begin
         chk("t3_b0", bit_log[0], 0);
         chk("t3_b1", bit_log[1], 0);
         chk("t3_b2", bit_log[2], 1);
      end

      // Single-beat words, reload in the done cycle (one bubble)
      bit_log.delete(); sel_log.delete();
      rdy_mode = 0;
      load(32'h0000_0003, 5'd0, 1'b1);
      wait_done();
      chk("t4_in_ready_at_done", in_ready, 1);
      load(32'hFFFF_FFFE, 5'd0, 1'b0);
      wait_done();
      chk("t4_beats", bit_log.size(), 2);
      if (bit_log.size() == 2) begin
         chk("t4_b0", bit_log[0], 1);
         chk("t4_b1", bit_log[1], 0);
         chk("t4_sel1", sel_log[1], 0);
      end

      // Reset mid-word aborts it
      bit_log.delete(); sel_log.delete();
      load(32'hFFFF_FFFF, 5'd31, 1'b0);
      begin
         int n;
         n = 0;
         while (bit_log.size() < 10 && n < 100) begin
            @(posedge clk); #1;
            n++;
         end
         if (bit_log.size() < 10) chk("t5_wait_timeout", 0, 1);
      end
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("t5_async_out_valid", out_valid, 0);
      chk("t5_async_in_ready", in_ready, 1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      bit_log.delete(); sel_log.delete();
      load(32'h0000_0000, 5'd7, 1'b1);
      wait_done();
      chk("t5_beats", bit_log.size(), 8);
      for (int i = 0; i < bit_log.size(); i++) chk("t5_zero_bit", bit_log[i], 0);

      // Randomized traffic; inputs keep changing while a word is in flight
      rdy_mode = 2;
      for (int c = 0; c < 4000; c++) begin
         @(posedge clk); #1;
         in_valid     = ($urandom_range(0, 3) == 0);
         in_data      = $urandom;
         in_count     = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
         in_msb_first = 1'($urandom);
      end
      in_valid = 1'b0;
      rdy_mode = 0;
      wait_ready();
      repeat (3) @(posedge clk);
      #1;
      chk("final_queue_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/mux_serializer_seq.md
Name: mux_serializer_seq

Overview:
- Sequencing stage directly upstream of the 32:1 multiplexer `mux32to1`.
- Accepts a 32-bit word over a valid/ready handshake and registers it onto the mux data input.
- Steps the 5-bit select through a programmable bit range, one step per accepted output beat.
- Emits the selected bit as a serial stream with valid/ready/last.
- Used wherever a parallel word must be shifted out bit-by-bit, e.g. a serial link transmitter or debug scan-out.

Parameters:
- WIDTH, 32, data word width. Must equal the mux input width.
- SEL_W, 5, select width, equal to clog2(WIDTH).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept a word.
- in_data  input  WIDTH  word to serialize.
- in_count  input  SEL_W  number of bits to send, minus 1 (0 sends 1 bit, 31 sends 32 bits).
- in_msb_first  input  1  1 = descending index from in_count down to 0; 0 = ascending index from 0 up to in_count.
- out_valid  output  1  out_bit is valid.
- out_ready  input  1  downstream accepts the beat.
- out_bit  output  1  selected bit, equal to word_reg[out_sel].
- out_last  output  1  current beat is the final bit of the word.
- out_sel  output  SEL_W  current mux select, exposed for debug and coverage.
- done  output  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- State machine has two states: IDLE and SHIFT.
- Reset (rst_n low, asynchronous) forces:
  - state = IDLE, word_reg = 0, sel = 0, remaining = 0, dir = 0.
  - out_valid = 0, out_last = 0, done = 0, in_ready = 1.
  - out_bit = word_reg[0] = 0.
- Reset asserted mid-word aborts the word immediately. The partial word is discarded and not resumed.
- in_ready = (state == IDLE). This is combinational from state only, with no dependence on in_valid.
- Load happens on a rising edge with in_valid && in_ready:
  - word_reg <= in_data; remaining <= in_count; dir <= in_msb_first.
  - sel <= in_msb_first ? in_count : 0.
  - state <= SHIFT.
- Latency: the word is accepted at edge N and the first bit is presented with out_valid = 1 in the cycle after edge N.
- SHIFT outputs:
  - out_valid = 1.
  - out_bit = mux output (combinational from word_reg and sel, no extra register).
  - out_last = (remaining == 0).
- Beat transfer occurs on a rising edge with out_valid && out_ready:
  - If out_last: state <= IDLE, done <= 1 for exactly one cycle.
  - Otherwise: remaining <= remaining - 1; sel <= dir ? sel - 1 : sel + 1.
- Stall: with out_ready = 0, word_reg, sel, remaining and all outputs hold stable, and out_valid stays 1.
- Inputs are ignored in SHIFT: in_data, in_count and in_msb_first changes have no effect, since in_ready = 0.
- Back-to-back words: one bubble cycle. IDLE lasts at least one cycle (in_ready = 1) before the next load.
- in_count = 0 gives a single beat with out_last = 1 on the first beat. The select points at bit 0 in both directions.
- Select never wraps, because the bound is in_count ≤ WIDTH-1:
  - descending mode ends at sel = 0;
  - ascending mode ends at sel = in_count.
- done and a simultaneous new in_valid: done pulses in the first IDLE cycle, and a load in that same cycle is legal.
- X-safety: out_bit is don't-care when out_valid = 0. The bench must not check it then.

Decomposition:
- Shared package `mux_pkg`:
  - localparams MUX_WIDTH = 32 and MUX_SEL_W = 5.
  - state typedef `ser_state_t` {IDLE, SHIFT}.
- Sub-module: instantiate the existing `mux32to1` with ports (S, I, Y) connected to sel, word_reg and out_bit.
- All sequencing logic (FSM, counter, word register) stays in this block.

Test Plan:
- Reset then release, with no stimulus -> in_ready = 1, out_valid = 0, done = 0, out_sel = 0.
- Load 32'hA5A5_0001, count 31, msb_first 0, out_ready held 1 -> 32 beats, LSB first: 1,0,0,0,... with out_last only on beat 32; done pulses one cycle later; in_ready returns to 1.
- Load 32'h8000_0003, count 31, msb_first 1 -> beats start 1,0,0,...; final two beats are 1,1; out_sel sequence 31 down to 0.
- Load 32'h0000_0004, count 2, msb_first 0, out_ready toggling 1,0,0,1,... -> exactly 3 beats 0,0,1; outputs frozen during every stall; out_last on the third beat only.
- Load any word with count 0 -> a single beat carrying in_data[0] with out_last = 1; done pulses; bubble before the next load is exactly one cycle.
- Load 32'hFFFF_FFFF, count 31; assert rst_n low after beat 10 -> out_valid drops with no clock edge; in_ready = 1 after release; a new load of 32'h0 serializes cleanly.
